scoreboard_register_file: RTL and testbench



---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_clear_fsm.sv | 33 +++
 rtl/scoreboard_register_file.sv | 82 ++++++++
 tb/tb_scoreboard_register_file.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and clear-FSM state type for the scoreboard register file
package regfile_pkg;
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;
  localparam int REGFILE_SP_INDEX = 2;
  localparam logic [31:0] REGFILE_SP_INIT = 32'h7FFF_EFFC;
  typedef enum logic [1:0] {CLR_IDLE, CLR_CLEAR, CLR_DONE} clr_state_t;
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: soft-clear sequencer walking one register index per cycle
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_active,
  output logic [ADDR_W-1:0] clr_index,
  output logic              clr_busy,
  output logic              clr_done
);
  clr_state_t state, state_nxt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= CLR_IDLE;
      clr_index <= '0;
    end else begin
      state     <= state_nxt;
      clr_index <= clr_active ? clr_index + 1'b1 : '0;
    end
  always_comb
    state_nxt = (state == CLR_IDLE)  ? (clr_req ? CLR_CLEAR : CLR_IDLE) :
                (state == CLR_CLEAR) ? (&clr_index ? CLR_DONE : CLR_CLEAR) :
                                       CLR_IDLE;
  always_comb begin
    clr_active = state == CLR_CLEAR;
    clr_busy   = state != CLR_IDLE;
    clr_done   = state == CLR_DONE;
  end
endmodule

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: multi-port register file with per-register busy scoreboard and soft clear
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int NREAD = 2,
  parameter int SP_INDEX = REGFILE_SP_INDEX,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(REGFILE_SP_INIT)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nxt;
  logic              clr_active, wr_ok, iss_ok;
  logic [ADDR_W-1:0] clr_index;
  // register 0 is hard-wired to zero, so its reset/clear value must stay zero
  function automatic logic [DATA_W-1:0] init_val(input int i);
    return (i == SP_INDEX && i != 0) ? SP_INIT : '0;
  endfunction
  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a);
    return (wr_ok && a == wr_addr) ? wr_data : regs[a];
  endfunction
  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr_req    (clr_req),
    .clr_active (clr_active),
    .clr_index  (clr_index),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );
  always_comb begin
    wr_ok  = wr_en && !clr_busy && wr_addr != '0;
    iss_ok = iss_en && !clr_busy && iss_addr != '0;
  end
  // issue is applied after writeback so a same-cycle issue keeps the register busy
  always_comb begin
    busy_nxt = busy;
    if (clr_active) busy_nxt[clr_index] = 1'b0;
    if (wr_ok) busy_nxt[wr_addr] = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= init_val(i);
    end else if (clr_active) begin
      regs[clr_index] <= init_val(int'(clr_index));
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) busy <= '0;
    else busy <= busy_nxt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rd_data  <= '0;
      rd_busy  <= '0;
      dbg_data <= '0;
    end else begin
      for (int k = 0; k < NREAD; k++) begin
        rd_data[k*DATA_W +: DATA_W] <= fwd(rd_addr[k*ADDR_W +: ADDR_W]);
        rd_busy[k]                  <= busy_nxt[rd_addr[k*ADDR_W +: ADDR_W]];
      end
      dbg_data <= fwd(dbg_addr);
    end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb_scoreboard_register_file: randomized check of the register file against a per-cycle reference model
module tb_scoreboard_register_file;
  localparam int AW = 5, DW = 32, NR = 2, DEPTH = 32;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic wr_en = 1'b0, iss_en = 1'b0, clr_req = 1'b0, clr_busy, clr_done;
  logic [AW-1:0] wr_addr = '0, iss_addr = '0, dbg_addr = '0;
  logic [DW-1:0] wr_data = '0, dbg_data;
  logic [3*AW-1:0] rd_addr3 = '0;
  logic [3*64-1:0] rd_data3;
  logic [2:0] rd_busy3;
  logic wr_en3 = 1'b0, clr_busy3, clr_done3;
  logic [AW-1:0] wr_addr3 = '0;
  logic [63:0] wr_data3 = '0, dbg_data3;
  logic [31:0] mem [DEPTH];
  logic busy_m [DEPTH];
  int pos, n_checks = 0, n_fail = 0;
  always #5 clock = ~clock;
  scoreboard_register_file dut (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );
  scoreboard_register_file #(.NREAD(3), .DATA_W(64)) dut3 (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr3), .rd_data(rd_data3), .rd_busy(rd_busy3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .iss_en(1'b0), .iss_addr(5'd0),
    .dbg_addr(5'd0), .dbg_data(dbg_data3), .clr_req(1'b0), .clr_busy(clr_busy3), .clr_done(clr_done3)
  );
  function automatic logic [31:0] rst_val(input int i);
    return i == 2 ? SP : 32'd0;
  endfunction
  function automatic logic [AW-1:0] raddr();
    return $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = rst_val(i);
      busy_m[i] = 1'b0;
    end
    pos = -1;
  endtask
  // pos: -1 idle, 0..DEPTH-1 index being cleared this cycle, DEPTH the done cycle
  task automatic cycle();
    logic [31:0] e_rd [NR];
    logic e_rb [NR];
    logic [31:0] e_dbg;
    logic [AW-1:0] a;
    bit idle, wok, iok;
    idle = pos < 0;
    wok = idle && wr_en && wr_addr != 0;
    iok = idle && iss_en && iss_addr != 0;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      e_rd[k] = (wok && a == wr_addr) ? wr_data : mem[a];
    end
    e_dbg = (wok && dbg_addr == wr_addr) ? wr_data : mem[dbg_addr];
    if (pos >= 0 && pos < DEPTH) begin
      mem[pos] = rst_val(pos);
      busy_m[pos] = 1'b0;
    end
    if (wok) begin
      mem[wr_addr] = wr_data;
      busy_m[wr_addr] = 1'b0;
    end
    if (iok) busy_m[iss_addr] = 1'b1;
    for (int k = 0; k < NR; k++) e_rb[k] = busy_m[rd_addr[k*AW +: AW]];
    pos = idle ? (clr_req ? 0 : -1) : (pos == DEPTH ? -1 : pos + 1);
    @(posedge clock);
    #1;
    for (int k = 0; k < NR; k++) begin
      check("rd_data", rd_data[k*DW +: DW], e_rd[k]);
      check("rd_busy", rd_busy[k], e_rb[k]);
    end
    check("dbg_data", dbg_data, e_dbg);
    check("clr_busy", clr_busy, pos >= 0);
    check("clr_done", clr_done, pos == DEPTH);
  endtask
  task automatic rand_inputs(input int clr_odds);
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = raddr();
    wr_en = $urandom_range(0, 1);
    wr_addr = raddr();
    wr_data = $urandom;
    iss_en = $urandom_range(0, 2) == 0;
    iss_addr = raddr();
    dbg_addr = raddr();
    clr_req = clr_odds > 0 && $urandom_range(0, clr_odds - 1) == 0;
  endtask
  task automatic quiet();
    wr_en = 0; iss_en = 0; clr_req = 0;
  endtask
  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_busy"}, rd_busy, 0);
    check({tag, "_dbg"}, dbg_data, 0);
    check({tag, "_clr_busy"}, clr_busy, 0);
    check({tag, "_clr_done"}, clr_done, 0);
    check({tag, "_rd_data3"}, rd_data3[63:0], 0);
  endtask
  initial begin
    int busy_cycles, done_at, guard;
    model_reset();
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    // stack pointer and ordinary reset values
    rd_addr = {5'd5, 5'd2};
    cycle();
    check("sp_reset", rd_data[31:0], SP);
    check("r5_reset", rd_data[63:32], 0);
    // write-through and register 0
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; rd_addr = {5'd7, 5'd0};
    cycle();
    check("wt_r7", rd_data[63:32], 32'hDEADBEEF);
    wr_addr = 0; rd_addr = {5'd0, 5'd0};
    cycle();
    check("r0_zero", rd_data[31:0], 0);
    // busy set by issue, cleared by writeback, set wins on collision
    wr_en = 0; iss_en = 1; iss_addr = 9; rd_addr = {5'd9, 5'd9};
    cycle();
    iss_en = 0;
    repeat (3) cycle();
    check("busy_held", rd_busy[0], 1);
    wr_en = 1; wr_addr = 9; wr_data = 32'h1234;
    cycle();
    check("busy_cleared", rd_busy[0], 0);
    iss_en = 1; iss_addr = 9; wr_data = 32'h5678;
    cycle();
    check("busy_collide", rd_busy[0], 1);
    check("data_collide", rd_data[31:0], 32'h5678);
    // fill every register, then soft clear with noise on ignored inputs
    for (int a = 1; a < DEPTH; a++) begin
      rand_inputs(0);
      wr_en = 1; wr_addr = AW'(a);
      cycle();
    end
    quiet();
    clr_req = 1;
    cycle();
    busy_cycles = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (clr_busy) busy_cycles++;
      if (clr_done) done_at = c;
      rand_inputs(0);
      if (!clr_busy) begin wr_en = 0; iss_en = 0; end
      clr_req = clr_busy && $urandom_range(0, 1) == 1;
      cycle();
    end
    check("clr_busy_len", busy_cycles, DEPTH + 1);
    check("clr_done_at", done_at, DEPTH + 1);
    quiet();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      cycle();
      check("clr_val", rd_data[31:0], rst_val(a));
      check("clr_busybit", rd_busy[0], 0);
    end
    // random traffic including occasional soft clears
    for (int c = 0; c < 800; c++) begin
      rand_inputs(48);
      cycle();
    end
    // reset in the middle of a clear pass
    quiet();
    guard = 0;
    while (clr_busy && guard < 40) begin
      cycle();
      guard++;
    end
    check("clr_idle_wait", clr_busy, 0);
    clr_req = 1;
    cycle();
    clr_req = 0;
    repeat (10) cycle();
    check("mid_clear_index", pos, 10);
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rand_inputs(0);
      wr_en = 0;
      cycle();
    end
    // wide, three-port instance: write-through on all ports and register 0
    quiet();
    wr_en3 = 1; wr_addr3 = 7; wr_data3 = 64'hDEADBEEF_0123_4567; rd_addr3 = {5'd7, 5'd7, 5'd7};
    cycle();
    for (int k = 0; k < 3; k++) check("wt3_r7", rd_data3[k*64 +: 64], 64'hDEADBEEF_0123_4567);
    wr_addr3 = 0; rd_addr3 = '0;
    cycle();
    for (int k = 0; k < 3; k++) check("wt3_r0", rd_data3[k*64 +: 64], 0);
    wr_en3 = 0; rd_addr3 = {5'd2, 5'd0, 5'd7};
    cycle();
    check("rd3_r7", rd_data3[63:0], 64'hDEADBEEF_0123_4567);
    check("rd3_r0", rd_data3[127:64], 0);
    check("rd3_sp", rd_data3[191:128], {32'd0, SP});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
